// File: rtl/pe_addr_sequencer.sv
// Purpose : NUM_CH independent PE-group address pointers with runtime limit/stride, wrap pulses and pass counters.
// Latency : en -> addr/wrap/pass_cnt one cycle; cfg_load takes effect on the next edge.
// Backpres: none by default. With PE_SEQ_GUARD_EN, fill/drain requests that would over/underflow are dropped and flag err.
module pe_addr_sequencer #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 3,
    parameter int PASS_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_load,
    input  logic [NUM_CH*ADDR_W-1:0]   cfg_limit,
    input  logic [NUM_CH*ADDR_W-1:0]   cfg_stride,
    input  logic [NUM_CH-1:0]          en,
    output logic [NUM_CH*ADDR_W-1:0]   addr,
    output logic [NUM_CH-1:0]          wrap,
    output logic [NUM_CH*PASS_W-1:0]   pass_cnt,
    output logic                       err
);

    localparam int AW1 = ADDR_W + 1;

    logic [ADDR_W-1:0] lim_q    [NUM_CH];
    logic [ADDR_W-1:0] str_q    [NUM_CH];
    logic [ADDR_W:0]   sum_x    [NUM_CH];
    logic [ADDR_W-1:0] adv_addr [NUM_CH];
    logic [NUM_CH-1:0] roll;
    logic [NUM_CH-1:0] cfg_ok;
    logic [NUM_CH-1:0] adv;
    logic              guard_err;

    // Candidate next pointer per channel, computed one bit wider so the limit compare cannot alias.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sum_x[k]    = {1'b0, addr[k*ADDR_W +: ADDR_W]} + {1'b0, str_q[k]};
            roll[k]     = sum_x[k] > {1'b0, lim_q[k]};
            adv_addr[k] = roll[k] ? ADDR_W'(sum_x[k] - {1'b0, lim_q[k]} - AW1'(1))
                                  : sum_x[k][ADDR_W-1:0];
            cfg_ok[k]   = (cfg_stride[k*ADDR_W +: ADDR_W] != '0) &&
                          ({1'b0, cfg_stride[k*ADDR_W +: ADDR_W]} <=
                           {1'b0, cfg_limit[k*ADDR_W +: ADDR_W]} + AW1'(1));
        end
    end

`ifdef PE_SEQ_GUARD_EN
    localparam int FILL  = NUM_CH - 2;
    localparam int DRAIN = NUM_CH - 1;

    logic [ADDR_W:0] occ;

    // Drop a drain on an empty buffer or a fill on a full one; each drop raises err.
    always_comb begin
        adv       = en;
        guard_err = 1'b0;
        if (en[DRAIN] && (occ == '0)) begin
            adv[DRAIN] = 1'b0;
            guard_err  = 1'b1;
        end
        if (en[FILL] && (occ == ({1'b0, lim_q[FILL]} + AW1'(1)))) begin
            adv[FILL] = 1'b0;
            guard_err = 1'b1;
        end
    end

    // Occupancy follows accepted fills minus accepted drains.
    always_ff @(posedge clk) begin
        if (!rst || cfg_load) begin
            occ <= '0;
        end else begin
            case ({adv[FILL], adv[DRAIN]})
                2'b10:   occ <= occ + AW1'(1);
                2'b01:   occ <= occ - AW1'(1);
                default: occ <= occ;
            endcase
        end
    end
`else
    assign adv       = en;
    assign guard_err = 1'b0;
`endif

    // Pointer, wrap, pass counter, config and error state; reset beats cfg_load beats en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr     <= '0;
            wrap     <= '0;
            pass_cnt <= '0;
            err      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                lim_q[k] <= '1;
                str_q[k] <= ADDR_W'(1);
            end
        end else if (cfg_load) begin
            addr     <= '0;
            wrap     <= '0;
            pass_cnt <= '0;
            err      <= ~&cfg_ok;
            for (int k = 0; k < NUM_CH; k++) begin
                if (cfg_ok[k]) begin
                    lim_q[k] <= cfg_limit[k*ADDR_W +: ADDR_W];
                    str_q[k] <= cfg_stride[k*ADDR_W +: ADDR_W];
                end
            end
        end else begin
            if (guard_err) begin
                err <= 1'b1;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (adv[k]) begin
                    addr[k*ADDR_W +: ADDR_W] <= adv_addr[k];
                    wrap[k]                  <= roll[k];
                    if (roll[k] && (pass_cnt[k*PASS_W +: PASS_W] != '1)) begin
                        pass_cnt[k*PASS_W +: PASS_W] <= pass_cnt[k*PASS_W +: PASS_W] + PASS_W'(1);
                    end
                end else begin
                    wrap[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_addr_sequencer.sv
// Purpose : Table vectors, directed corner sequences and random traffic checked against a behavioural model.
// Latency : model is updated at each rising edge and outputs are compared 1 ns later.
// Backpres: guard rules mirrored in the model only when PE_SEQ_GUARD_EN is defined.
module tb_pe_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [11:0] cfg_limit;
    logic [11:0] cfg_stride;
    logic [3:0]  en;
    logic [11:0] addr,  addr_s;
    logic [3:0]  wrap,  wrap_s;
    logic [31:0] pass_cnt;
    logic [7:0]  pass_s;
    logic        err,   err_s;

    always #5 clk = ~clk;

    pe_addr_sequencer #(.NUM_CH(4), .ADDR_W(3), .PASS_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_limit(cfg_limit),
        .cfg_stride(cfg_stride), .en(en), .addr(addr), .wrap(wrap),
        .pass_cnt(pass_cnt), .err(err));

    // Narrow pass counter copy, driven identically, to exercise saturation.
    pe_addr_sequencer #(.NUM_CH(4), .ADDR_W(3), .PASS_W(2)) u_sat (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_limit(cfg_limit),
        .cfg_stride(cfg_stride), .en(en), .addr(addr_s), .wrap(wrap_s),
        .pass_cnt(pass_s), .err(err_s));

    // Behavioural model state
    int m_addr [4];
    int m_lim  [4];
    int m_str  [4];
    int m_pass [4];
    int m_pass2[4];
    bit m_wrap [4];
    bit m_err;
    int m_occ;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        logic        r;
        logic        ld;
        logic [11:0] lim;
        logic [11:0] str;
        logic [3:0]  e;
        logic [11:0] x_addr;
        logic [3:0]  x_wrap;
        logic [31:0] x_pass;
        logic        x_err;
    } vec_t;

    vec_t tbl[23];

    localparam logic [11:0] LIM_A   = 12'hFF7; // ch1 limit 6, others 7
    localparam logic [11:0] STR_A   = 12'h251; // ch1 stride 2, others 1
    localparam logic [11:0] STR_BAD = 12'h211; // ch2 stride 0
    localparam logic [11:0] STR_1   = 12'h249; // all strides 1

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit ok;
        bit acc[4];
        int n, l, s;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                m_addr[k] = 0; m_wrap[k] = 0; m_pass[k] = 0; m_pass2[k] = 0;
                m_lim[k] = 7; m_str[k] = 1;
            end
            m_err = 0; m_occ = 0;
        end else if (cfg_load) begin
            ok = 1;
            for (int k = 0; k < 4; k++) begin
                l = int'(cfg_limit[k*3 +: 3]);
                s = int'(cfg_stride[k*3 +: 3]);
                if (s != 0 && s <= l + 1) begin
                    m_lim[k] = l; m_str[k] = s;
                end else begin
                    ok = 0;
                end
                m_addr[k] = 0; m_wrap[k] = 0; m_pass[k] = 0; m_pass2[k] = 0;
            end
            m_err = !ok; m_occ = 0;
        end else begin
            for (int k = 0; k < 4; k++) acc[k] = en[k];
`ifdef PE_SEQ_GUARD_EN
            if (acc[3] && m_occ == 0) begin acc[3] = 0; m_err = 1; end
            if (acc[2] && m_occ == m_lim[2] + 1) begin acc[2] = 0; m_err = 1; end
            m_occ = m_occ + int'(acc[2]) - int'(acc[3]);
`endif
            for (int k = 0; k < 4; k++) begin
                m_wrap[k] = 0;
                if (acc[k]) begin
                    n = m_addr[k] + m_str[k];
                    if (n > m_lim[k]) begin
                        m_addr[k] = n - (m_lim[k] + 1);
                        m_wrap[k] = 1;
                        if (m_pass[k]  < 255) m_pass[k]++;
                        if (m_pass2[k] < 3)   m_pass2[k]++;
                    end else begin
                        m_addr[k] = n;
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        logic [11:0] ea;
        logic [3:0]  ew;
        logic [31:0] ep;
        logic [7:0]  ep2;
        for (int k = 0; k < 4; k++) begin
            ea[k*3 +: 3] = m_addr[k][2:0];
            ew[k]        = m_wrap[k];
            ep[k*8 +: 8] = m_pass[k][7:0];
            ep2[k*2 +: 2] = m_pass2[k][1:0];
        end
        chk("model_addr", 64'(addr), 64'(ea));
        chk("model_wrap", 64'(wrap), 64'(ew));
        chk("model_pass", 64'(pass_cnt), 64'(ep));
        chk("model_err",  64'(err), 64'(m_err));
        chk("model_pass_sat", 64'(pass_s), 64'(ep2));
    endtask

    task automatic step(input logic r, input logic ld, input logic [11:0] li,
                        input logic [11:0] st, input logic [3:0] e);
        rst = r; cfg_load = ld; cfg_limit = li; cfg_stride = st; en = e;
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    function automatic vec_t mk(input logic r, input logic ld, input logic [11:0] li,
                                input logic [11:0] st, input logic [3:0] e,
                                input logic [11:0] xa, input logic [3:0] xw,
                                input logic [31:0] xp, input logic xe);
        vec_t v;
        v.r = r; v.ld = ld; v.lim = li; v.str = st; v.e = e;
        v.x_addr = xa; v.x_wrap = xw; v.x_pass = xp; v.x_err = xe;
        return v;
    endfunction

    initial begin
        // Reset, then ch0 walks 1..7 and wraps on the 8th advance
        tbl[0] = mk(0, 0, 12'h000, 12'h000, 4'b0000, 12'h000, 4'b0000, 32'h0, 0);
        for (int i = 1; i <= 7; i++)
            tbl[i] = mk(1, 0, 12'h000, 12'h000, 4'b0001, 12'(i), 4'b0000, 32'h0, 0);
        tbl[8]  = mk(1, 0, 12'h000, 12'h000, 4'b0001, 12'h000, 4'b0001, 32'h1, 0);
        // ch1 limit 6 stride 2: 2,4,6 then wraps to 1
        tbl[9]  = mk(1, 1, LIM_A, STR_A,   4'b0000, 12'h000, 4'b0000, 32'h0, 0);
        tbl[10] = mk(1, 0, LIM_A, STR_A,   4'b0010, 12'h010, 4'b0000, 32'h0, 0);
        tbl[11] = mk(1, 0, LIM_A, STR_A,   4'b0010, 12'h020, 4'b0000, 32'h0, 0);
        tbl[12] = mk(1, 0, LIM_A, STR_A,   4'b0010, 12'h030, 4'b0000, 32'h0, 0);
        tbl[13] = mk(1, 0, LIM_A, STR_A,   4'b0010, 12'h008, 4'b0010, 32'h100, 0);
        // Invalid ch2 stride: err set, ch2 keeps stride 1 / limit 7
        tbl[14] = mk(1, 1, LIM_A, STR_BAD, 4'b0000, 12'h000, 4'b0000, 32'h0, 1);
        tbl[15] = mk(1, 0, LIM_A, STR_BAD, 4'b0100, 12'h040, 4'b0000, 32'h0, 1);
        tbl[16] = mk(1, 1, LIM_A, STR_A,   4'b0000, 12'h000, 4'b0000, 32'h0, 0);
        // cfg_load beats en; reset mid-run clears everything
        tbl[17] = mk(1, 0, LIM_A, STR_A,   4'b0001, 12'h001, 4'b0000, 32'h0, 0);
        tbl[18] = mk(1, 0, LIM_A, STR_A,   4'b0001, 12'h002, 4'b0000, 32'h0, 0);
        tbl[19] = mk(1, 0, LIM_A, STR_A,   4'b0001, 12'h003, 4'b0000, 32'h0, 0);
        tbl[20] = mk(1, 1, LIM_A, STR_A,   4'b0001, 12'h000, 4'b0000, 32'h0, 0);
        tbl[21] = mk(1, 0, LIM_A, STR_A,   4'b0111, 12'h051, 4'b0000, 32'h0, 0);
        tbl[22] = mk(0, 0, LIM_A, STR_A,   4'b0111, 12'h000, 4'b0000, 32'h0, 0);

        rst = 0; cfg_load = 0; cfg_limit = '0; cfg_stride = '0; en = '0;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].r, tbl[i].ld, tbl[i].lim, tbl[i].str, tbl[i].e);
            chk($sformatf("tbl%0d_addr", i), 64'(addr), 64'(tbl[i].x_addr));
            chk($sformatf("tbl%0d_wrap", i), 64'(wrap), 64'(tbl[i].x_wrap));
            chk($sformatf("tbl%0d_pass", i), 64'(pass_cnt), 64'(tbl[i].x_pass));
            chk($sformatf("tbl%0d_err", i),  64'(err), 64'(tbl[i].x_err));
        end

`ifndef PE_SEQ_GUARD_EN
        // ch3 limit 0: every advance wraps; the 2-bit counter saturates at 3
        step(0, 0, 12'h000, 12'h000, 4'b0000);
        step(1, 1, 12'h1FF, STR_1, 4'b0000);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 12'h1FF, STR_1, 4'b1000);
            chk("sat_addr3", 64'(addr[11:9]), 64'(0));
            chk("sat_wrap3", 64'(wrap[3]), 64'(1));
            chk("sat_pass3_w8", 64'(pass_cnt[31:24]), 64'(i));
            chk("sat_pass3_w2", 64'(pass_s[7:6]), 64'((i > 3) ? 3 : i));
        end
        step(1, 0, 12'h1FF, STR_1, 4'b0000);
        chk("sat_wrap3_drop", 64'(wrap[3]), 64'(0));
`else
        // Fill ch2 (limit 3) against drain ch3
        step(0, 0, 12'h000, 12'h000, 4'b0000);
        step(1, 1, 12'hEFF, STR_1, 4'b0000);
        step(1, 0, 12'hEFF, STR_1, 4'b1000);
        chk("grd_empty_drain_addr3", 64'(addr[11:9]), 64'(0));
        chk("grd_empty_drain_err", 64'(err), 64'(1));
        step(1, 1, 12'hEFF, STR_1, 4'b0000);
        chk("grd_reload_err", 64'(err), 64'(0));
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 12'hEFF, STR_1, 4'b0100);
            chk("grd_fill_addr2", 64'(addr[8:6]), 64'(i % 4));
        end
        chk("grd_fill_err_clear", 64'(err), 64'(0));
        step(1, 0, 12'hEFF, STR_1, 4'b0100);
        chk("grd_full_addr2", 64'(addr[8:6]), 64'(0));
        chk("grd_full_err", 64'(err), 64'(1));
        step(1, 0, 12'hEFF, STR_1, 4'b1000);
        chk("grd_drain_addr3", 64'(addr[11:9]), 64'(1));
        step(1, 0, 12'hEFF, STR_1, 4'b1100);
        chk("grd_both_addr2", 64'(addr[8:6]), 64'(1));
        chk("grd_both_addr3", 64'(addr[11:9]), 64'(2));
`endif

        // Random traffic including invalid configs and occasional reset
        step(0, 0, 12'h000, 12'h000, 4'b0000);
        for (int i = 0; i < 600; i++) begin
            logic r, ld;
            logic [11:0] li, st;
            r  = ($urandom_range(0, 63) != 0);
            ld = ($urandom_range(0, 15) == 0);
            li = 12'($urandom);
            st = 12'($urandom);
            step(r, ld, li, st, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
